// File: rtl/mbr_pkg.sv
// Shared constants and FSM encoding for the MBR partition-table scanner.
package mbr_pkg;

  localparam logic [15:0] MBR_PT_BASE   = 16'h01BE;
  localparam int          MBR_PT_STRIDE = 16;
  localparam int          MBR_OFS_TYPE  = 4;
  localparam int          MBR_OFS_LBA   = 8;
  localparam int          MBR_OFS_SIZE  = 12;
  localparam logic [15:0] MBR_SIG0_ADR  = 16'h01FE;
  localparam logic [15:0] MBR_SIG1_ADR  = 16'h01FF;
  localparam logic [7:0]  MBR_SIG0_VAL  = 8'h55;
  localparam logic [7:0]  MBR_SIG1_VAL  = 8'hAA;

  localparam logic [7:0]  FAT32_CHS     = 8'h0B;
  localparam logic [7:0]  FAT32_LBA     = 8'h0C;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EVAL,
    DONE
  } mbr_state_t;

  function automatic logic [15:0] entry_base(input int idx);
    return MBR_PT_BASE + 16'(MBR_PT_STRIDE * idx);
  endfunction

endpackage

// File: rtl/mbr_entry_cap.sv
// Captures the type, start LBA and sector count of one partition-table entry
// and flags whether that entry is a usable FAT32 partition.
module mbr_entry_cap
  import mbr_pkg::*;
#(
  parameter logic [15:0] BASE   = MBR_PT_BASE,
  parameter logic [7:0]  TYPE_A = FAT32_CHS,
  parameter logic [7:0]  TYPE_B = FAT32_LBA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        cap,
  input  logic [15:0] addr,
  input  logic [7:0]  data,
  input  logic        sig_pass,
  output logic [31:0] lba,
  output logic [31:0] size,
  output logic        qual
);

  logic [7:0]  ptype;
  logic [15:0] ofs;
  logic        hit;

  // Unsigned wrap makes addresses below BASE land far outside the 16-byte window.
  assign ofs = addr - BASE;
  assign hit = cap && (ofs[15:4] == 12'd0);

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      ptype <= '0;
      lba   <= '0;
      size  <= '0;
    end else if (clr) begin
      ptype <= '0;
      lba   <= '0;
      size  <= '0;
    end else if (hit) begin
      if (ofs[3:0] == 4'(MBR_OFS_TYPE))
        ptype <= data;
      else if (ofs[3:2] == 2'(MBR_OFS_LBA / 4))
        lba[{ofs[1:0], 3'b000} +: 8] <= data;
      else if (ofs[3:2] == 2'(MBR_OFS_SIZE / 4))
        size[{ofs[1:0], 3'b000} +: 8] <= data;
    end
  end

  assign qual = ((ptype == TYPE_A) || (ptype == TYPE_B)) &&
                (lba != 32'd0) && (size != 32'd0) && sig_pass;

endmodule

// File: rtl/mbr_scan.sv
// Scans the MBR partition table of a received sector and reports the first
// non-empty FAT32 partition.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   SCAN  | capturing table and signature bytes until byte 0x1FF
//   EVAL  | checking entries 0..NPART-1, one per cycle, then committing
//   DONE  | result held until the next start
module mbr_scan
  import mbr_pkg::*;
#(
  parameter int         NPART     = 4,
  parameter logic [7:0] TYPE_A    = FAT32_CHS,
  parameter logic [7:0] TYPE_B    = FAT32_LBA,
  parameter int         CHECK_SIG = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sbdone,
  input  logic        mbrprmwe,
  input  logic [7:0]  DATASI,
  input  logic [15:0] PTDATAPNTR,
  output logic        done,
  output logic        fat32valid,
  output logic        sigok,
  output logic [1:0]  PARTIDX,
  output logic [31:0] FAT32SA,
  output logic [31:0] FAT32SZ
);

  mbr_state_t  state;
  logic [2:0]  k;
  logic [7:0]  sig0, sig1;
  logic        cap, sig_pass;

  logic        cand_found;
  logic [1:0]  cand_idx;
  logic [31:0] cand_sa, cand_sz;

  logic        qual_arr [4];
  logic [31:0] lba_arr  [4];
  logic [31:0] size_arr [4];

  assign cap      = sbdone && mbrprmwe && (state == SCAN);
  assign sigok    = (sig0 == MBR_SIG0_VAL) && (sig1 == MBR_SIG1_VAL);
  assign sig_pass = sigok || (CHECK_SIG == 0);

  for (genvar g = 0; g < 4; g++) begin : g_ent
    if (g < NPART) begin : g_cap
      mbr_entry_cap #(
        .BASE   (entry_base(g)),
        .TYPE_A (TYPE_A),
        .TYPE_B (TYPE_B)
      ) u_cap (
        .clk      (clk),
        .reset    (reset),
        .clr      (start),
        .cap      (cap),
        .addr     (PTDATAPNTR),
        .data     (DATASI),
        .sig_pass (sig_pass),
        .lba      (lba_arr[g]),
        .size     (size_arr[g]),
        .qual     (qual_arr[g])
      );
    end else begin : g_nil
      assign lba_arr[g]  = '0;
      assign size_arr[g] = '0;
      assign qual_arr[g] = 1'b0;
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      k          <= '0;
      sig0       <= '0;
      sig1       <= '0;
      cand_found <= 1'b0;
      cand_idx   <= '0;
      cand_sa    <= '0;
      cand_sz    <= '0;
      done       <= 1'b0;
      fat32valid <= 1'b0;
      PARTIDX    <= '0;
      FAT32SA    <= '0;
      FAT32SZ    <= '0;
    end else if (start) begin
      state      <= SCAN;
      k          <= '0;
      sig0       <= '0;
      sig1       <= '0;
      cand_found <= 1'b0;
      cand_idx   <= '0;
      cand_sa    <= '0;
      cand_sz    <= '0;
      done       <= 1'b0;
      fat32valid <= 1'b0;
      PARTIDX    <= '0;
      FAT32SA    <= '0;
      FAT32SZ    <= '0;
    end else begin
      case (state)
        SCAN: begin
          if (cap) begin
            if (PTDATAPNTR == MBR_SIG0_ADR)
              sig0 <= DATASI;
            if (PTDATAPNTR == MBR_SIG1_ADR) begin
              sig1  <= DATASI;
              k     <= '0;
              state <= EVAL;
            end
          end
        end
        EVAL: begin
          // k == NPART is the extra commit cycle so all outputs move together.
          if (k == 3'(NPART)) begin
            state      <= DONE;
            done       <= 1'b1;
            fat32valid <= cand_found;
            PARTIDX    <= cand_idx;
            FAT32SA    <= cand_sa;
            FAT32SZ    <= cand_sz;
          end else begin
            if (!cand_found && qual_arr[k[1:0]]) begin
              cand_found <= 1'b1;
              cand_idx   <= k[1:0];
              cand_sa    <= lba_arr[k[1:0]];
              cand_sz    <= size_arr[k[1:0]];
            end
            k <= k + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mbr_scan.sv
// Directed bench for mbr_scan: a byte-level model predicts each scan result
// into a queue, popped and compared when done rises.
module tb_mbr_scan;

  logic        clk = 1'b1;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        sbdone = 1'b0;
  logic        mbrprmwe = 1'b0;
  logic [7:0]  DATASI = '0;
  logic [15:0] PTDATAPNTR = '0;

  logic        done, fat32valid, sigok;
  logic [1:0]  PARTIDX;
  logic [31:0] FAT32SA, FAT32SZ;

  logic        done_n, fv_n, sigok_n;
  logic [1:0]  idx_n;
  logic [31:0] sa_n, sz_n;

  always #5 clk = ~clk;

  mbr_scan #(.NPART(4), .CHECK_SIG(1)) dut (
    .clk(clk), .reset(reset), .start(start), .sbdone(sbdone),
    .mbrprmwe(mbrprmwe), .DATASI(DATASI), .PTDATAPNTR(PTDATAPNTR),
    .done(done), .fat32valid(fat32valid), .sigok(sigok),
    .PARTIDX(PARTIDX), .FAT32SA(FAT32SA), .FAT32SZ(FAT32SZ)
  );

  mbr_scan #(.NPART(4), .CHECK_SIG(0)) dut_ns (
    .clk(clk), .reset(reset), .start(start), .sbdone(sbdone),
    .mbrprmwe(mbrprmwe), .DATASI(DATASI), .PTDATAPNTR(PTDATAPNTR),
    .done(done_n), .fat32valid(fv_n), .sigok(sigok_n),
    .PARTIDX(idx_n), .FAT32SA(sa_n), .FAT32SZ(sz_n)
  );

  typedef struct {
    logic        fv;
    logic        sok;
    logic [1:0]  idx;
    logic [31:0] sa;
    logic [31:0] sz;
    logic        fv_ns;
    logic [1:0]  idx_ns;
    logic [31:0] sa_ns;
    logic [31:0] sz_ns;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] pkt     [512];
  logic [7:0] cap_mem [512];
  int         vectors = 0;
  int         miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: first entry with FAT32 type, non-zero LBA/size, and a good
  // signature (the signature term is dropped for the CHECK_SIG=0 instance).
  function automatic exp_t model();
    exp_t r;
    logic sig;
    r = '{default: '0};
    sig = (cap_mem[510] == 8'h55) && (cap_mem[511] == 8'hAA);
    r.sok = sig;
    for (int i = 0; i < 4; i++) begin
      int b;
      logic [7:0]  t;
      logic [31:0] l, s;
      logic q;
      b = 446 + 16 * i;
      t = cap_mem[b + 4];
      l = {cap_mem[b + 11], cap_mem[b + 10], cap_mem[b + 9], cap_mem[b + 8]};
      s = {cap_mem[b + 15], cap_mem[b + 14], cap_mem[b + 13], cap_mem[b + 12]};
      q = ((t == 8'h0B) || (t == 8'h0C)) && (l != 0) && (s != 0);
      if (q && sig && !r.fv) begin
        r.fv = 1'b1; r.idx = 2'(i); r.sa = l; r.sz = s;
      end
      if (q && !r.fv_ns) begin
        r.fv_ns = 1'b1; r.idx_ns = 2'(i); r.sa_ns = l; r.sz_ns = s;
      end
    end
    return r;
  endfunction

  task automatic clear_model();
    for (int a = 0; a < 512; a++) cap_mem[a] = 8'h00;
  endtask

  task automatic set_entry(input int i, input logic [7:0] t, input logic [31:0] l,
                           input logic [31:0] s);
    int b;
    b = 446 + 16 * i;
    pkt[b + 4] = t;
    for (int j = 0; j < 4; j++) begin
      pkt[b + 8 + j]  = l[8*j +: 8];
      pkt[b + 12 + j] = s[8*j +: 8];
    end
  endtask

  task automatic new_pkt(input logic [7:0] s0, input logic [7:0] s1);
    for (int a = 0; a < 512; a++) pkt[a] = 8'($urandom);
    for (int i = 0; i < 4; i++) set_entry(i, 8'h00, 32'h0, 32'h0);
    pkt[510] = s0;
    pkt[511] = s1;
  endtask

  task automatic drive_byte(input int a, input logic [7:0] d, input bit we);
    @(posedge clk);
    sbdone     = 1'b1;
    mbrprmwe   = we;
    PTDATAPNTR = 16'(a);
    DATASI     = d;
    if (we) cap_mem[a] = d;
  endtask

  task automatic send_range(input int lo, input int hi, input int glo, input int ghi);
    for (int a = lo; a <= hi; a++)
      drive_byte(a, pkt[a], !((a >= glo) && (a <= ghi)));
  endtask

  task automatic pulse_start();
    @(posedge clk);
    sbdone = 1'b0;
    start  = 1'b1;
    @(posedge clk);
    start  = 1'b0;
    clear_model();
  endtask

  // done is due 5 falling edges after the 0x1FF capture edge; sampled on
  // rising edges, that is the 6th rising edge after the 0x1FF drive edge.
  task automatic wait_done(input string tag);
    int   cyc;
    exp_t e;
    @(posedge clk);
    sbdone   = 1'b0;
    mbrprmwe = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd6);
    vectors++;
    assert (sb.size() > 0) else begin
      miscompares++;
      $error("FAIL %s_queue: observed empty expected entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_done"},    32'(done),       32'd1);
    chk({tag, "_fv"},      32'(fat32valid), 32'(e.fv));
    chk({tag, "_sigok"},   32'(sigok),      32'(e.sok));
    chk({tag, "_idx"},     32'(PARTIDX),    32'(e.idx));
    chk({tag, "_sa"},      FAT32SA,         e.sa);
    chk({tag, "_sz"},      FAT32SZ,         e.sz);
    chk({tag, "_ns_done"}, 32'(done_n),     32'd1);
    chk({tag, "_ns_fv"},   32'(fv_n),       32'(e.fv_ns));
    chk({tag, "_ns_sigok"},32'(sigok_n),    32'(e.sok));
    chk({tag, "_ns_idx"},  32'(idx_n),      32'(e.idx_ns));
    chk({tag, "_ns_sa"},   sa_n,            e.sa_ns);
    chk({tag, "_ns_sz"},   sz_n,            e.sz_ns);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_done"},  32'(done),       32'd0);
    chk({tag, "_fv"},    32'(fat32valid), 32'd0);
    chk({tag, "_sigok"}, 32'(sigok),      32'd0);
    chk({tag, "_idx"},   32'(PARTIDX),    32'd0);
    chk({tag, "_sa"},    FAT32SA,         32'd0);
    chk({tag, "_sz"},    FAT32SZ,         32'd0);
  endtask

  initial begin
    clear_model();

    // reset state
    #12;
    chk_all_zero("rst");
    @(posedge clk);
    reset = 1'b0;

    // single FAT32 partition, then hold and async reset while DONE
    pulse_start();
    new_pkt(8'h55, 8'hAA);
    set_entry(0, 8'h0B, 32'h0000_2000, 32'h0003_E000);
    send_range(0, 511, -1, -1);
    sb.push_back(model());
    wait_done("single");
    chk("single_exp_sa", FAT32SA, 32'h0000_2000);
    repeat (3) @(posedge clk);
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_sz", FAT32SZ, 32'h0003_E000);
    #2 reset = 1'b1;
    #1 chk_all_zero("rst_done");
    @(posedge clk);
    reset = 1'b0;

    // priority: first qualifying entry wins
    pulse_start();
    new_pkt(8'h55, 8'hAA);
    set_entry(0, 8'h07, 32'h0000_0100, 32'h0000_0100);
    set_entry(2, 8'h0C, 32'h0000_0800, 32'h0000_1000);
    set_entry(3, 8'h0B, 32'h0000_9000, 32'h0000_2000);
    send_range(0, 511, -1, -1);
    sb.push_back(model());
    wait_done("prio");
    chk("prio_exp_idx", 32'(PARTIDX), 32'd2);

    // bad signature
    pulse_start();
    new_pkt(8'h00, 8'h00);
    set_entry(0, 8'h0B, 32'h0000_2000, 32'h0003_E000);
    send_range(0, 511, -1, -1);
    sb.push_back(model());
    wait_done("badsig");
    chk("badsig_exp_fv", 32'(fat32valid), 32'd0);
    chk("badsig_exp_ns_fv", 32'(fv_n), 32'd1);

    // zero LBA / zero size
    pulse_start();
    new_pkt(8'h55, 8'hAA);
    set_entry(0, 8'h0B, 32'h0000_0000, 32'h0000_0010);
    set_entry(1, 8'h0B, 32'h0000_0010, 32'h0000_0000);
    send_range(0, 511, -1, -1);
    sb.push_back(model());
    wait_done("zero");

    // entry-0 bytes gated by mbrprmwe
    pulse_start();
    new_pkt(8'h55, 8'hAA);
    set_entry(0, 8'h0B, 32'h0000_2000, 32'h0000_3000);
    set_entry(1, 8'h0C, 32'h0000_4000, 32'h0000_8000);
    send_range(0, 511, 'h1BE, 'h1CD);
    sb.push_back(model());
    wait_done("gate");
    chk("gate_exp_idx", 32'(PARTIDX), 32'd1);

    // repeated address: last write wins
    pulse_start();
    new_pkt(8'h55, 8'hAA);
    set_entry(0, 8'h0B, 32'h0000_1000, 32'h0000_1000);
    set_entry(1, 8'h0C, 32'h0000_5000, 32'h0000_6000);
    send_range(0, 'h1FD, -1, -1);
    drive_byte('h1C2, 8'h83, 1'b1);
    send_range('h1FE, 511, -1, -1);
    sb.push_back(model());
    wait_done("rewrite");

    // start coincident with sbdone drops that byte and restarts the scan
    pulse_start();
    new_pkt(8'h55, 8'hAA);
    set_entry(0, 8'h0B, 32'h0000_7000, 32'h0000_7000);
    send_range(0, 'h1D0, -1, -1);
    @(posedge clk);
    sbdone = 1'b1; mbrprmwe = 1'b1; PTDATAPNTR = 16'h01C2; DATASI = 8'h0B;
    start  = 1'b1;
    clear_model();
    @(posedge clk);
    start  = 1'b0;
    sbdone = 1'b0;
    new_pkt(8'h55, 8'hAA);
    set_entry(0, 8'h0B, 32'h0000_0500, 32'h0000_0600);
    set_entry(3, 8'h0B, 32'h0001_2345, 32'h0000_6789);
    send_range(0, 511, 'h1C2, 'h1C2);
    sb.push_back(model());
    wait_done("restart");
    chk("restart_exp_idx", 32'(PARTIDX), 32'd3);

    // reset while EVAL is in progress
    pulse_start();
    new_pkt(8'h55, 8'hAA);
    set_entry(1, 8'h0C, 32'h0000_0A00, 32'h0000_0B00);
    send_range(0, 511, -1, -1);
    @(posedge clk);
    sbdone = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_all_zero("rst_eval");
    @(posedge clk);
    reset = 1'b0;
    clear_model();
    drive_byte('h1FE, 8'h55, 1'b1);
    drive_byte('h1FF, 8'hAA, 1'b1);
    @(posedge clk);
    sbdone = 1'b0;
    repeat (12) @(posedge clk);
    chk("rst_no_done", 32'(done), 32'd0);
    chk("rst_no_sigok", 32'(sigok), 32'd0);

    // recovery after reset
    pulse_start();
    new_pkt(8'h55, 8'hAA);
    set_entry(2, 8'h0C, 32'hDEAD_0001, 32'h0000_0042);
    send_range(0, 511, -1, -1);
    sb.push_back(model());
    wait_done("recover");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mbr_scan.md
# mbr_scan

Parametrised successor to the single-entry MBR field latch in the DAT-line MBR stage. It captures up to four MBR partition entries and the 0x55AA boot signature from the byte stream. It then evaluates the entries in order and reports the first partition that is both FAT32-typed and non-empty: its start sector, its sector count and its index. The block sits between the DAT input shift register / packet byte counter and the FAT32 boot-sector read stage, which waits on `done`.

## Interface
Parameters:
- NPART, 4: number of partition entries scanned, 1..4, starting at entry 0.
- TYPE_A, 8'h0B: first accepted partition type (FAT32 CHS).
- TYPE_B, 8'h0C: second accepted partition type (FAT32 LBA).
- CHECK_SIG, 1: when 1, `fat32valid` additionally requires bytes 0x1FE/0x1FF = 0x55/0xAA.

Ports:
- clk  in  1  clock; all registers update on the falling edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle pulse; clears captured fields and outputs, enters SCAN.
- sbdone  in  1  shift-byte-done strobe; DATASI is valid.
- mbrprmwe  in  1  MBR_READ_PARAM state enable; bytes are ignored when low.
- DATASI  in  8  received byte.
- PTDATAPNTR  in  16  byte index within the 512-byte packet.
- done  out  1  scan complete; held until start or reset.
- fat32valid  out  1  a qualifying partition was found (valid only while done=1).
- sigok  out  1  signature matched.
- PARTIDX  out  2  index of the selected entry.
- FAT32SA  out  32  start LBA of the selected entry, little-endian assembled.
- FAT32SZ  out  32  sector count of the selected entry.

## Operation
- Capture strobe: cap = sbdone & mbrprmwe & (state==SCAN).
- Entry i base address B = 0x1BE + 16*i:
  - type byte at B+4;
  - LBA bytes at B+8..B+11, LSB first;
  - size bytes at B+12..B+15, LSB first.
- Signature bytes: 0x1FE and 0x1FF.
- Bytes at any other address are ignored. Entries at or above NPART are never captured.
- A repeated address overwrites the earlier byte (last write wins).
- FSM states:
  - IDLE -> SCAN on start.
  - SCAN -> EVAL on a cap with PTDATAPNTR==0x1FF.
  - EVAL walks entries 0..NPART-1, one per cycle, using counter k.
  - EVAL -> DONE after entry NPART-1 is evaluated.
  - DONE -> SCAN on start.
- Entry i qualifies when all of the following hold:
  - type==TYPE_A or type==TYPE_B;
  - LBA != 0;
  - size != 0;
  - sigok, or CHECK_SIG==0.
- The first qualifying entry (lowest index) wins. Later qualifying entries never replace it.
- No qualifying entry: fat32valid=0, PARTIDX=0, FAT32SA=0, FAT32SZ=0.
- sigok reflects the captured signature bytes regardless of CHECK_SIG.
- start in any state, including mid-SCAN or mid-EVAL, clears every captured byte, k and all outputs, and enters SCAN.
- start coincident with sbdone: start wins and the byte is dropped.
- Reset values: state IDLE, done 0, fat32valid 0, sigok 0, PARTIDX 0, FAT32SA 0, FAT32SZ 0, all captured bytes 0.

## Timing
- Capture: the byte is written on the falling edge where cap=1. No pipeline stage on the input.
- Let edge E be the capture of byte 0x1FF. EVAL occupies edges E+1..E+NPART.
- done, fat32valid, PARTIDX, FAT32SA and FAT32SZ update together on edge E+NPART+1. Latency is NPART+1 cycles, i.e. 5 cycles for NPART=4.
- Outputs are stable and glitch-free while done=1. Consumers sample them only while done=1.
- sbdone is at most one byte per cycle. Back-to-back strobes on consecutive cycles are legal.
- Reset asserted mid-operation: all outputs drop asynchronously. No scan resumes until the next start.

## Structure
- Shared package mbr_pkg holds:
  - constants MBR_PT_BASE=0x1BE, MBR_PT_STRIDE=16, MBR_OFS_TYPE=4, MBR_OFS_LBA=8, MBR_OFS_SIZE=12, MBR_SIG0_ADR=0x1FE, MBR_SIG1_ADR=0x1FF;
  - FAT32 type codes 0x0B and 0x0C;
  - the FSM state encoding (IDLE, SCAN, EVAL, DONE).
- Sub-module mbr_entry_cap:
  - instantiated NPART times via generate, with the base address as a parameter;
  - holds the type, LBA and size registers of one entry;
  - outputs the captured fields plus a combinational "qualifies" flag.
- Top level holds the FSM, counter k, signature capture and the output registers.

## Test plan
- Single FAT32 partition: entry 0 type 0x0B, LBA 0x00002000, size 0x0003E000, signature 55 AA -> done 5 cycles after byte 0x1FF; fat32valid=1, PARTIDX=0, FAT32SA=0x00002000, FAT32SZ=0x0003E000.
- Priority: entry 0 type 0x07 (NTFS), entry 2 type 0x0C LBA 0x800, entry 3 type 0x0B LBA 0x9000 -> PARTIDX=2, FAT32SA=0x800.
- Bad signature, CHECK_SIG=1: valid entry 0, bytes 0x1FE/0x1FF = 00 00 -> done=1, sigok=0, fat32valid=0, FAT32SA=0. Same stimulus with CHECK_SIG=0 -> fat32valid=1.
- Zero fields: entry 0 type 0x0B with LBA 0, entry 1 type 0x0B with size 0 -> fat32valid=0, PARTIDX=0.
- Gating: identical packet with mbrprmwe=0 on the entry-0 bytes -> entry 0 not captured. start asserted mid-packet on the same cycle as sbdone -> that byte dropped, scan restarts, result from the rescanned packet only.
- Reset: assert reset between EVAL edges with done pending -> all outputs 0 immediately; no done until a new start and a full packet.
